// File: rtl/id_fwd_scoreboard_if.sv
// Bundle of the ID-stage scoreboard signals: master is the pipeline/ID side,
// slave is the scoreboard itself.
interface id_fwd_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 3
);
  logic                     flush;
  logic                     iss_vld;
  logic                     iss_we;
  logic [ADDR_W-1:0]        iss_waddr;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rf_data;
  logic [DEPTH-1:0]         res_vld;
  logic [DEPTH*DATA_W-1:0]  res_data;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     stall;
  logic                     busy;
  logic [31:0]              stall_cnt;

  modport master (
    output flush, iss_vld, iss_we, iss_waddr, rd_en, rd_addr, rf_data,
           res_vld, res_data,
    input  rd_data, stall, busy, stall_cnt
  );

  modport slave (
    input  flush, iss_vld, iss_we, iss_waddr, rd_en, rd_addr, rf_data,
           res_vld, res_data,
    output rd_data, stall, busy, stall_cnt
  );
endinterface

// File: rtl/id_fwd_scoreboard.sv
// Operand-forwarding / hazard scoreboard for the ID stage: a DEPTH-slot shift
// of in-flight writes (slot0=EX). Optional stall counter under SB_STALL_CNT_EN.
module id_fwd_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 3
) (
  input logic               clk,
  input logic               rst_n,
  id_fwd_scoreboard_if.slave sb
);

  // Handshake: iss_vld is the ID-stage valid and ~stall is its ready. An
  // instruction is accepted into slot0 on a rising edge only when iss_vld=1,
  // stall=0 and flush=0; otherwise slot0 receives a bubble.

  logic [DEPTH-1:0]                slot_vld;
  logic [DEPTH-1:0]                slot_rdy;
  logic [DEPTH-1:0][ADDR_W-1:0]    slot_addr;
  logic [DEPTH-1:0][DATA_W-1:0]    slot_data;

  logic [DEPTH-1:0][DATA_W-1:0]    res_words;
  logic [NUM_RD-1:0][ADDR_W-1:0]   src_addr;
  logic [NUM_RD-1:0][DATA_W-1:0]   rf_words;
  logic [DEPTH-1:0]                live_rdy;
  logic [DEPTH-1:0][DATA_W-1:0]    live_data;
  logic [NUM_RD-1:0]               hazard;
  logic [NUM_RD-1:0][DATA_W-1:0]   fwd_data;
  logic                            stall_int;
  logic                            issue_vld;

  assign res_words = sb.res_data;
  assign src_addr  = sb.rd_addr;
  assign rf_words  = sb.rf_data;

  always_comb begin
    live_rdy  = '0;
    live_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      live_rdy[k]  = slot_rdy[k] | sb.res_vld[k];
      live_data[k] = sb.res_vld[k] ? res_words[k] : slot_data[k];
    end
  end

  // Walk oldest to youngest so the youngest matching slot overrides.
  always_comb begin
    hazard   = '0;
    fwd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      fwd_data[p] = rf_words[p];
      if (sb.rd_en[p] && (src_addr[p] != '0)) begin
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (slot_vld[k] && (slot_addr[k] == src_addr[p])) begin
            if (live_rdy[k]) begin
              fwd_data[p] = live_data[k];
              hazard[p]   = 1'b0;
            end else begin
              fwd_data[p] = rf_words[p];
              hazard[p]   = 1'b1;
            end
          end
        end
      end
    end
  end

  assign stall_int = sb.iss_vld & (|hazard) & ~sb.flush;
  assign issue_vld = sb.iss_vld & sb.iss_we & ~stall_int & ~sb.flush &
                     (sb.iss_waddr != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_vld  <= '0;
      slot_rdy  <= '0;
      slot_addr <= '0;
      slot_data <= '0;
    end else begin
      slot_vld[0]  <= issue_vld;
      slot_rdy[0]  <= 1'b0;
      slot_addr[0] <= sb.iss_waddr;
      slot_data[0] <= '0;
      for (int k = 1; k < DEPTH; k++) begin
        slot_vld[k]  <= slot_vld[k-1] & ~sb.flush;
        slot_rdy[k]  <= slot_vld[k-1] & live_rdy[k-1];
        slot_addr[k] <= slot_addr[k-1];
        slot_data[k] <= live_data[k-1];
      end
    end
  end

  // Outputs are forced quiet while reset is held, before the first edge.
  assign sb.rd_data = rst_n ? fwd_data : '0;
  assign sb.stall   = rst_n & stall_int;
  assign sb.busy    = rst_n & (|slot_vld);

`ifdef SB_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_int && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign sb.stall_cnt = rst_n ? stall_cnt_q : 32'd0;
`else
  assign sb.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_fwd_scoreboard.sv
// Bench for id_fwd_scoreboard: directed hazard scenarios then random traffic,
// checked against an instruction-level model through an expected queue.
module tb_id_fwd_scoreboard;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 3;
`ifdef SB_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [NUM_RD-1:0][DATA_W-1:0] rd;
    logic [NUM_RD-1:0]             dc;
    logic                          stall;
    logic                          busy;
    logic [31:0]                   cnt;
  } exp_t;
  localparam int W = $bits(exp_t);

  // One in-flight write: which slot produces its result and what value.
  typedef struct {
    bit                vld;
    logic [ADDR_W-1:0] addr;
    int                stage;
    logic [DATA_W-1:0] val;
  } ent_t;

  logic clk;
  logic rst_n;
  id_fwd_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
                         .DEPTH(DEPTH)) sb_if ();

  id_fwd_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
                      .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus state and model ----------------
  logic [W-1:0]                  exp_q[$];
  int                            checks = 0;
  int                            failures = 0;
  logic                          flush_b, iss_vld_b, iss_we_b;
  logic [ADDR_W-1:0]             iss_waddr_b;
  logic [NUM_RD-1:0]             en_b;
  logic [NUM_RD-1:0][ADDR_W-1:0] ra_b;
  int                            nxt_stage;
  logic [DATA_W-1:0]             nxt_val;
  logic [DATA_W-1:0]             rf[2**ADDR_W];
  ent_t                          pipe[$];
  logic [31:0]                   cnt_m;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    flush_b = 1'b0; iss_vld_b = 1'b0; iss_we_b = 1'b0; iss_waddr_b = '0;
    en_b = '0; ra_b = '0; nxt_stage = 0; nxt_val = '0;
  endtask

  task automatic issue(input int addr, input int stage, input logic [DATA_W-1:0] val);
    iss_vld_b = 1'b1; iss_we_b = 1'b1; iss_waddr_b = ADDR_W'(addr);
    nxt_stage = stage; nxt_val = val;
  endtask

  task automatic read(input int p, input int addr);
    iss_vld_b = 1'b1; en_b[p] = 1'b1; ra_b[p] = ADDR_W'(addr);
  endtask

  // One clock: drive inputs, predict outputs, queue them, then advance model.
  task automatic drive_cycle(input bit [2:0] chk, input logic [DATA_W-1:0] w_rd,
                             input bit w_stall, input logic [31:0] w_cnt);
    exp_t                          e;
    logic [NUM_RD-1:0][DATA_W-1:0] rfd;
    logic [DEPTH-1:0][DATA_W-1:0]  rdat;
    logic [DEPTH-1:0]              rv;
    bit                            any_hz, found;
    ent_t                          old, n;
    for (int p = 0; p < NUM_RD; p++) rfd[p] = rf[ra_b[p]];
    for (int k = 0; k < DEPTH; k++) begin
      if (pipe[k].vld && pipe[k].stage == k) begin
        rv[k] = 1'b1; rdat[k] = pipe[k].val;
      end else if (pipe[k].vld) begin
        rv[k] = 1'b0; rdat[k] = $urandom;
      end else begin
        rv[k] = 1'($urandom_range(0, 1)); rdat[k] = $urandom;
      end
    end
    sb_if.flush = flush_b; sb_if.iss_vld = iss_vld_b; sb_if.iss_we = iss_we_b;
    sb_if.iss_waddr = iss_waddr_b; sb_if.rd_en = en_b; sb_if.rd_addr = ra_b;
    sb_if.rf_data = rfd; sb_if.res_vld = rv; sb_if.res_data = rdat;

    e = '0;
    any_hz = 1'b0;
    if (rst_n) begin
      for (int p = 0; p < NUM_RD; p++) begin
        e.rd[p] = rfd[p];
        found = 1'b0;
        if (en_b[p] && ra_b[p] != '0) begin
          for (int k = 0; k < DEPTH; k++) begin
            if (!found && pipe[k].vld && pipe[k].addr == ra_b[p]) begin
              found = 1'b1;
              if (pipe[k].stage <= k) e.rd[p] = pipe[k].val;
              else begin e.dc[p] = 1'b1; any_hz = 1'b1; end
            end
          end
        end
      end
      e.stall = iss_vld_b && any_hz && !flush_b;
      for (int k = 0; k < DEPTH; k++) if (pipe[k].vld) e.busy = 1'b1;
      e.cnt = cnt_m;
    end
    exp_q.push_back(e);

    if (chk != 3'b000) begin
      @(negedge clk);
      if (chk[0]) check("dir_rd0", 64'(sb_if.rd_data[DATA_W-1:0]), 64'(w_rd));
      if (chk[1]) check("dir_stall", 64'(sb_if.stall), 64'(w_stall));
      if (chk[2]) check("dir_cnt", 64'(sb_if.stall_cnt), 64'(w_cnt));
    end
    @(posedge clk);

    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) pipe[k].vld = 1'b0;
      cnt_m = '0;
    end else begin
      old = pipe.pop_back();
      if (old.vld) rf[old.addr] = old.val;
      if (flush_b) for (int k = 0; k < DEPTH - 1; k++) pipe[k].vld = 1'b0;
      n.vld   = iss_vld_b && iss_we_b && !e.stall && !flush_b && iss_waddr_b != '0;
      n.addr  = iss_waddr_b;
      n.stage = nxt_stage;
      n.val   = nxt_val;
      pipe.push_front(n);
      if (CNT_EN && e.stall && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 32'd1;
    end
    #1;
  endtask

  task automatic cyc();
    drive_cycle(3'b000, '0, 1'b0, '0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int p = 0; p < NUM_RD; p++)
        if (!e.dc[p]) check("rd_data", 64'(sb_if.rd_data[p*DATA_W +: DATA_W]), 64'(e.rd[p]));
      check("stall", 64'(sb_if.stall), 64'(e.stall));
      check("busy", 64'(sb_if.busy), 64'(e.busy));
      check("stall_cnt", 64'(sb_if.stall_cnt), 64'(e.cnt));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) rf[i] = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ent_t z;
      z.vld = 1'b0; z.addr = '0; z.stage = 0; z.val = '0;
      pipe.push_back(z);
    end
    cnt_m = '0;
    rst_n = 1'b0;
    set_idle();
    @(posedge clk); #1;
    read(0, 3);
    drive_cycle(3'b111, '0, 1'b0, '0);
    set_idle(); cyc();
    rst_n = 1'b1;

    // back-to-back dependency forwarded from slot0
    set_idle(); issue(3, 0, 32'h11); cyc();
    set_idle(); read(0, 3); drive_cycle(3'b011, 32'h11, 1'b0, '0);
    // load-use: one stall, then forward from slot1
    set_idle(); issue(4, 1, 32'h22); cyc();
    set_idle(); read(0, 4); drive_cycle(3'b010, '0, 1'b1, '0);
    set_idle(); read(0, 4); drive_cycle(3'b011, 32'h22, 1'b0, '0);
    // youngest writer wins
    set_idle(); issue(5, 0, 32'hAA); cyc();
    set_idle(); issue(5, 0, 32'hBB); cyc();
    set_idle(); read(0, 5); drive_cycle(3'b011, 32'hBB, 1'b0, '0);
    set_idle(); read(0, 5); drive_cycle(3'b011, 32'hBB, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) begin set_idle(); cyc(); end
    // r0 never tracked
    set_idle(); issue(0, 0, 32'h5A); cyc();
    set_idle(); read(0, 0); drive_cycle(3'b011, '0, 1'b0, '0);
    // flush kills a pending unready write
    set_idle(); issue(6, 2, 32'h66); cyc();
    set_idle(); read(0, 6); flush_b = 1'b1; drive_cycle(3'b010, '0, 1'b0, '0);
    set_idle(); read(0, 6); drive_cycle(3'b011, '0, 1'b0, '0);
    // stall counter, then reset in the middle of a stall
    rst_n = 1'b0; set_idle(); cyc(); rst_n = 1'b1;
    set_idle(); issue(7, 2, 32'h77); cyc();
    set_idle(); read(0, 7); drive_cycle(3'b010, '0, 1'b1, '0);
    set_idle(); read(0, 7); drive_cycle(3'b010, '0, 1'b1, '0);
    set_idle(); issue(9, 2, 32'h99); read(0, 7);
    drive_cycle(3'b111, 32'h77, 1'b0, CNT_EN ? 32'd2 : 32'd0);
    set_idle(); read(0, 9); drive_cycle(3'b010, '0, 1'b1, '0);
    set_idle(); read(0, 9); drive_cycle(3'b110, '0, 1'b1, CNT_EN ? 32'd3 : 32'd0);
    rst_n = 1'b0; set_idle(); read(0, 9); drive_cycle(3'b111, '0, 1'b0, '0);
    rst_n = 1'b1; set_idle(); read(0, 9); drive_cycle(3'b111, '0, 1'b0, '0);

    // random traffic with small address space to force collisions
    for (int i = 0; i < 800; i++) begin
      set_idle();
      rst_n       = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      flush_b     = ($urandom_range(0, 15) == 0);
      iss_vld_b   = ($urandom_range(0, 3) != 0);
      iss_we_b    = ($urandom_range(0, 3) != 0);
      iss_waddr_b = ADDR_W'($urandom_range(0, 7));
      for (int p = 0; p < NUM_RD; p++) begin
        en_b[p] = 1'($urandom_range(0, 1));
        ra_b[p] = ADDR_W'($urandom_range(0, 7));
      end
      nxt_stage = $urandom_range(0, DEPTH - 1);
      nxt_val   = $urandom;
      cyc();
    end
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin set_idle(); cyc(); end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
